// File: rtl/tiny16_pkg.sv
// Shared tiny16 definitions: loader FSM state encoding, frame sync byte and
// the word/address widths used by the memory, the CPU and the loader.
// Optional build macro: TINY16_LOADER_CHECKSUM_EN adds the checksum state.
package tiny16_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
`ifdef TINY16_LOADER_CHECKSUM_EN
    ST_CSUM    = 3'd5,
`endif
    ST_DONE    = 3'd6
  } state_t;

endpackage

// File: rtl/tiny16_uart_rx.sv
// 8N1 UART byte receiver for the tiny16 loader.
// RX is double-flopped before use. A falling edge starts a frame, the start
// bit is re-checked half a bit later, then one sample per CLK_DIV cycles:
// 8 data bits LSB first and the stop bit on the 10th sample.
// Outputs: byte_valid is a one-cycle strobe with data held stable in that
// cycle; frame_err is a one-cycle strobe when the stop bit reads low. There
// is no ready: the consumer must take the byte in the strobe cycle.
module tiny16_uart_rx #(
  parameter int CLK_DIV = 139
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

  logic [1:0]    sync;
  logic          rx_s;
  logic          rx_prev;
  logic          active;
  logic [CW-1:0] cnt;
  logic [3:0]    bitn;
  logic [7:0]    shreg;

  assign rx_s = sync[1];
  assign data = shreg;

  // Synchroniser, edge detect, bit timing and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync       <= 2'b11;
      rx_prev    <= 1'b1;
      active     <= 1'b0;
      cnt        <= '0;
      bitn       <= 4'd0;
      shreg      <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync       <= {sync[0], rx};
      rx_prev    <= rx_s;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (!active) begin
        if (rx_prev && !rx_s) begin
          active <= 1'b1;
          cnt    <= HALF_LAST;
          bitn   <= 4'd0;
        end
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        cnt <= BIT_LAST;
        if (bitn == 4'd0) begin
          // Start bit high at mid-bit means the edge was a glitch.
          if (rx_s) active <= 1'b0;
          else      bitn   <= 4'd1;
        end else if (bitn != 4'd9) begin
          shreg <= {rx_s, shreg[7:1]};
          bitn  <= bitn + 4'd1;
        end else begin
          active <= 1'b0;
          if (rx_s) byte_valid <= 1'b1;
          else      frame_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tiny16_loader.sv
// tiny16 serial program loader. Receives A5, LEN_HI, LEN_LO, then LEN words
// (high byte first) over UART and writes them to memory from address 0,
// holding the CPU in reset until a complete load.
// Optional build macro: TINY16_LOADER_CHECKSUM_EN expects one trailing byte
// equal to the mod-256 sum of LEN_HI, LEN_LO and all data bytes.
// The FSM state is exported on state_dbg.
module tiny16_loader #(
  parameter int CLK_DIV = 139,
  parameter int ADDR_W  = tiny16_pkg::ADDR_W,
  parameter int DATA_W  = tiny16_pkg::WORD_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_DATA,
  output logic              CPU_RST,
  output logic              DONE,
  output logic              ERR,
  output logic              BUSY,
  output logic [2:0]        state_dbg
);

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_ferr;

  tiny16_uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk       (CLK),
    .rst       (RST),
    .rx        (RX),
    .byte_valid(rx_valid),
    .data      (rx_byte),
    .frame_err (rx_ferr)
  );

  tiny16_pkg::state_t state, state_n;
  logic [7:0]        len_hi, len_hi_n;
  logic [7:0]        hi, hi_n;
  logic [15:0]       rem, rem_n;
  logic [ADDR_W-1:0] addr, addr_n, mem_addr_n;
  logic [DATA_W-1:0] mem_data_n;
  logic              mem_we_n, cpu_rst_n, done_n, err_n, busy_n;

  assign state_dbg = state;

`ifdef TINY16_LOADER_CHECKSUM_EN
  logic [7:0] csum, csum_n;

  // Running checksum: cleared on sync, accumulates length and data bytes.
  always_comb begin
    csum_n = csum;
    if (rx_valid) begin
      case (state)
        tiny16_pkg::ST_IDLE, tiny16_pkg::ST_DONE:
          if (rx_byte == tiny16_pkg::SYNC_BYTE) csum_n = 8'h00;
        tiny16_pkg::ST_LEN_HI, tiny16_pkg::ST_LEN_LO,
        tiny16_pkg::ST_DATA_HI, tiny16_pkg::ST_DATA_LO:
          csum_n = csum + rx_byte;
        default: csum_n = csum;
      endcase
    end
  end

  // Checksum register.
  always_ff @(posedge CLK) begin
    if (RST) csum <= 8'h00;
    else     csum <= csum_n;
  end
`endif

  // Next-state and registered-output logic of the frame FSM.
  always_comb begin
    state_n    = state;
    len_hi_n   = len_hi;
    hi_n       = hi;
    rem_n      = rem;
    addr_n     = addr;
    mem_we_n   = 1'b0;
    mem_addr_n = MEM_ADDR;
    mem_data_n = MEM_DATA;
    cpu_rst_n  = CPU_RST;
    done_n     = DONE;
    err_n      = ERR;
    busy_n     = BUSY;
    if (rx_ferr && state != tiny16_pkg::ST_IDLE && state != tiny16_pkg::ST_DONE) begin
      // Broken byte mid-frame: abandon the load, keep the CPU held.
      state_n   = tiny16_pkg::ST_IDLE;
      err_n     = 1'b1;
      busy_n    = 1'b0;
      cpu_rst_n = 1'b1;
    end else if (rx_valid) begin
      case (state)
        tiny16_pkg::ST_IDLE, tiny16_pkg::ST_DONE: begin
          if (rx_byte == tiny16_pkg::SYNC_BYTE) begin
            state_n   = tiny16_pkg::ST_LEN_HI;
            busy_n    = 1'b1;
            cpu_rst_n = 1'b1;
            done_n    = 1'b0;
            err_n     = 1'b0;
            addr_n    = '0;
          end
        end
        tiny16_pkg::ST_LEN_HI: begin
          len_hi_n = rx_byte;
          state_n  = tiny16_pkg::ST_LEN_LO;
        end
        tiny16_pkg::ST_LEN_LO: begin
          if ({len_hi, rx_byte} == 16'd0) begin
            state_n   = tiny16_pkg::ST_DONE;
            done_n    = 1'b1;
            busy_n    = 1'b0;
            cpu_rst_n = 1'b0;
          end else begin
            rem_n   = {len_hi, rx_byte};
            state_n = tiny16_pkg::ST_DATA_HI;
          end
        end
        tiny16_pkg::ST_DATA_HI: begin
          hi_n    = rx_byte;
          state_n = tiny16_pkg::ST_DATA_LO;
        end
        tiny16_pkg::ST_DATA_LO: begin
          mem_we_n   = 1'b1;
          mem_addr_n = addr;
          mem_data_n = DATA_W'({hi, rx_byte});
          addr_n     = addr + ADDR_W'(1);
          rem_n      = rem - 16'd1;
          if (rem == 16'd1) begin
`ifdef TINY16_LOADER_CHECKSUM_EN
            state_n = tiny16_pkg::ST_CSUM;
`else
            state_n   = tiny16_pkg::ST_DONE;
            done_n    = 1'b1;
            busy_n    = 1'b0;
            cpu_rst_n = 1'b0;
`endif
          end else begin
            state_n = tiny16_pkg::ST_DATA_HI;
          end
        end
`ifdef TINY16_LOADER_CHECKSUM_EN
        tiny16_pkg::ST_CSUM: begin
          if (rx_byte == csum) begin
            state_n   = tiny16_pkg::ST_DONE;
            done_n    = 1'b1;
            busy_n    = 1'b0;
            cpu_rst_n = 1'b0;
          end else begin
            state_n   = tiny16_pkg::ST_IDLE;
            err_n     = 1'b1;
            busy_n    = 1'b0;
            cpu_rst_n = 1'b1;
          end
        end
`endif
        default: state_n = tiny16_pkg::ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= tiny16_pkg::ST_IDLE;
      len_hi   <= 8'h00;
      hi       <= 8'h00;
      rem      <= 16'd0;
      addr     <= '0;
      MEM_WE   <= 1'b0;
      MEM_ADDR <= '0;
      MEM_DATA <= '0;
      CPU_RST  <= 1'b1;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      state    <= state_n;
      len_hi   <= len_hi_n;
      hi       <= hi_n;
      rem      <= rem_n;
      addr     <= addr_n;
      MEM_WE   <= mem_we_n;
      MEM_ADDR <= mem_addr_n;
      MEM_DATA <= mem_data_n;
      CPU_RST  <= cpu_rst_n;
      DONE     <= done_n;
      ERR      <= err_n;
      BUSY     <= busy_n;
    end
  end

endmodule

// File: tb/tb_tiny16_loader.sv
// Testbench for tiny16_loader (CLK_DIV=4). Frames are described as byte
// lists; a frame-level model derives the expected memory writes and final
// flags from the frame rules, and a monitor scores every MEM_WE cycle.
// Honours TINY16_LOADER_CHECKSUM_EN like the design.
module tb_tiny16_loader;

  localparam int CLK_DIV = 4;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        cpu_rst, done, err, busy;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  fq[$];
  logic [15:0] wq[$];
  logic [15:0] dut_mem [0:255];
  logic        prev_we = 1'b0;
  bit          e_done, e_err, e_busy, e_cpu;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  tiny16_loader #(.CLK_DIV(CLK_DIV)) dut (
    .CLK      (clk),
    .RST      (rst),
    .RX       (rx),
    .MEM_WE   (mem_we),
    .MEM_ADDR (mem_addr),
    .MEM_DATA (mem_data),
    .CPU_RST  (cpu_rst),
    .DONE     (done),
    .ERR      (err),
    .BUSY     (busy),
    .state_dbg(state_dbg)
  );

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exceeded, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every write cycle is matched against the next expected (addr,data).
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      dut_mem[mem_addr[7:0]] = mem_data;
      chk("we_single_cycle", {31'd0, prev_we}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_addr, mem_data);
      end else begin
        chk("write", {mem_addr, mem_data}, exp_q.pop_front());
      end
    end
    prev_we = mem_we;
  end

  // ---------------- model ----------------
  // Frame-level rules: bytes before the sync are ignored, words are written
  // to 0,1,2.. only if their low byte arrived before any cut (bad stop bit
  // or reset), and the final flags follow from how the frame ended.
  task automatic model_frame(input int bad_idx, input int rst_idx);
    int p, len, cut, lo, endi;
    logic [7:0] sum;
    p = 0;
    while (p < fq.size() && fq[p] != SYNC) p++;
    cut = fq.size();
    if (bad_idx >= 0 && bad_idx < cut) cut = bad_idx;
    if (rst_idx >= 0 && rst_idx < cut) cut = rst_idx;
    len = int'({fq[p+1], fq[p+2]});
    sum = fq[p+1] + fq[p+2];
    for (int k = 0; k < len; k++) begin
      lo = p + 4 + 2 * k;
      if (lo < fq.size()) sum = sum + fq[lo-1] + fq[lo];
      if (lo < cut) exp_q.push_back({16'(k), fq[lo-1], fq[lo]});
    end
    endi = p + 3 + 2 * len;
    e_busy = 1'b0;
    if (rst_idx >= 0) begin
      e_done = 1'b0; e_err = 1'b0; e_cpu = 1'b1;
    end else if (bad_idx >= 0) begin
      e_done = 1'b0; e_err = 1'b1; e_cpu = 1'b1;
    end else begin
`ifdef TINY16_LOADER_CHECKSUM_EN
      if (endi < fq.size() && fq[endi] == sum) begin
        e_done = 1'b1; e_err = 1'b0; e_cpu = 1'b0;
      end else begin
        e_done = 1'b0; e_err = 1'b1; e_cpu = 1'b1;
      end
`else
      e_done = 1'b1; e_err = 1'b0; e_cpu = 1'b0;
`endif
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CLK_DIV) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(!bad_stop);
    rx = 1'b1;
    repeat (3 * CLK_DIV) @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Appends a well-formed frame carrying the words in wq to fq.
  task automatic build_frame();
    logic [7:0] s;
    fq.push_back(SYNC);
    fq.push_back(8'(wq.size() >> 8));
    fq.push_back(8'(wq.size()));
    s = 8'(wq.size() >> 8) + 8'(wq.size());
    foreach (wq[i]) begin
      fq.push_back(wq[i][15:8]);
      fq.push_back(wq[i][7:0]);
      s = s + wq[i][15:8] + wq[i][7:0];
    end
`ifdef TINY16_LOADER_CHECKSUM_EN
    fq.push_back(s);
`endif
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) dut_mem[i] = 16'hDEAD;
  endtask

  task automatic run_frame(input int bad_idx, input int rst_idx);
    exp_q.delete();
    model_frame(bad_idx, rst_idx);
    for (int i = 0; i < fq.size(); i++) begin
      if (i == rst_idx) begin
        pulse_rst();
        break;
      end
      send_byte(fq[i], i == bad_idx);
      if (i == bad_idx) break;
    end
    repeat (4) @(negedge clk);
    chk("done", {31'd0, done}, {31'd0, e_done});
    chk("err", {31'd0, err}, {31'd0, e_err});
    chk("busy", {31'd0, busy}, {31'd0, e_busy});
    chk("cpu_rst", {31'd0, cpu_rst}, {31'd0, e_cpu});
    chk("writes_drained", exp_q.size(), 32'd0);
    if (rst_idx >= 0) begin
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
      chk("rst_mem_data", {16'd0, mem_data}, 32'd0);
    end
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lead, nw, r, p;
    rx  = 1'b1;
    rst = 1'b1;
    clear_mem();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("reset_mem_data", {16'd0, mem_data}, 32'd0);
    chk("reset_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_state", {29'd0, state_dbg}, {29'd0, tiny16_pkg::ST_IDLE});

    // LD/LD/ADD program, model pinned to hand-computed writes
    fq.delete(); wq.delete();
    wq.push_back(16'h1501); wq.push_back(16'h1702); wq.push_back(16'h3430);
    build_frame();
    exp_q.delete();
    model_frame(-1, -1);
    chk("model_nwrites", exp_q.size(), 32'd3);
    chk("model_w0", exp_q[0], 32'h0000_1501);
    chk("model_w1", exp_q[1], 32'h0001_1702);
    chk("model_w2", exp_q[2], 32'h0002_3430);
    run_frame(-1, -1);
    chk("prog_mem0", {16'd0, dut_mem[0]}, 32'h1501);
    chk("prog_mem1", {16'd0, dut_mem[1]}, 32'h1702);
    chk("prog_mem2", {16'd0, dut_mem[2]}, 32'h3430);
    chk("prog_done_lit", {31'd0, done}, 32'd1);
    chk("prog_state", {29'd0, state_dbg}, {29'd0, tiny16_pkg::ST_DONE});

    // Zero-length frame
    clear_mem();
    fq.delete(); wq.delete();
    build_frame();
    run_frame(-1, -1);
    chk("len0_mem0_untouched", {16'd0, dut_mem[0]}, 32'hDEAD);

    // Leading garbage before the sync byte
    clear_mem();
    fq.delete(); wq.delete();
    fq.push_back(8'h00); fq.push_back(8'hFF);
    wq.push_back(16'h1234);
    build_frame();
    run_frame(-1, -1);
    chk("lead_mem0", {16'd0, dut_mem[0]}, 32'h1234);

    // Framing error on the low byte of word 0
    clear_mem();
    fq.delete();
    fq.push_back(SYNC); fq.push_back(8'h00); fq.push_back(8'h02);
    fq.push_back(8'hAB); fq.push_back(8'hCD);
    run_frame(4, -1);
    chk("ferr_err_lit", {31'd0, err}, 32'd1);
    chk("ferr_mem0_untouched", {16'd0, dut_mem[0]}, 32'hDEAD);

    // Reset between the bytes of word 1, then a clean reload
    clear_mem();
    fq.delete(); wq.delete();
    wq.push_back(16'h1111); wq.push_back(16'h2222); wq.push_back(16'h3333);
    build_frame();
    run_frame(-1, 6);
    chk("rst_mem0_kept", {16'd0, dut_mem[0]}, 32'h1111);
    chk("rst_mem1_unwritten", {16'd0, dut_mem[1]}, 32'hDEAD);
    fq.delete(); wq.delete();
    wq.push_back(16'h4444); wq.push_back(16'h5555);
    build_frame();
    run_frame(-1, -1);
    chk("reload_mem0", {16'd0, dut_mem[0]}, 32'h4444);
    chk("reload_mem1", {16'd0, dut_mem[1]}, 32'h5555);

`ifdef TINY16_LOADER_CHECKSUM_EN
    // Checksum accepted and rejected
    fq.delete();
    fq.push_back(SYNC); fq.push_back(8'h00); fq.push_back(8'h01);
    fq.push_back(8'h12); fq.push_back(8'h34); fq.push_back(8'h47);
    run_frame(-1, -1);
    chk("csum_ok_done_lit", {31'd0, done}, 32'd1);
    fq.delete();
    fq.push_back(SYNC); fq.push_back(8'h00); fq.push_back(8'h01);
    fq.push_back(8'h12); fq.push_back(8'h34); fq.push_back(8'h48);
    run_frame(-1, -1);
    chk("csum_bad_err_lit", {31'd0, err}, 32'd1);
    chk("csum_bad_cpu_lit", {31'd0, cpu_rst}, 32'd1);
`endif

    // Randomized frames with occasional framing errors and resets
    for (int n = 0; n < 10; n++) begin
      fq.delete(); wq.delete();
      lead = $urandom_range(0, 2);
      for (int i = 0; i < lead; i++) begin
        logic [7:0] g;
        g = 8'($urandom_range(0, 255));
        if (g == SYNC) g = 8'h00;
        fq.push_back(g);
      end
      nw = $urandom_range(0, 5);
      for (int i = 0; i < nw; i++) wq.push_back(16'($urandom_range(0, 65535)));
      build_frame();
      p = lead;
      r = $urandom_range(0, 4);
      if (r == 0)      run_frame($urandom_range(p + 1, fq.size() - 1), -1);
      else if (r == 1) run_frame(-1, $urandom_range(p + 1, fq.size() - 1));
      else             run_frame(-1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
